// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: ALU opcodes, arbiter states
// and the legality check applied before an op reaches the ALU.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_op_t;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'b00,
      ARB_EXEC = 2'b01,
      ARB_RESP = 2'b10
   } arb_state_t;

   function automatic logic is_legal_op(input logic [2:0] op);
      logic ok;
      ok = 1'b0;
      case (op)
         ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub/and/or/signed slt, plus a zero flag.
// Unimplemented opcodes produce zero.
module alu
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] in1_i,
   input  logic [DATA_WIDTH-1:0] in2_i,
   input  logic [2:0]            ctrl_i,
   output logic [DATA_WIDTH-1:0] out_o,
   output logic                  eq_o
);

   logic slt;

   assign slt = $signed(in1_i) < $signed(in2_i);

   always_comb begin
      out_o = '0;
      case (ctrl_i)
         ALU_ADD: out_o = in1_i + in2_i;
         ALU_SUB: out_o = in1_i - in2_i;
         ALU_AND: out_o = in1_i & in2_i;
         ALU_OR:  out_o = in1_i | in2_i;
         ALU_SLT: out_o = {{(DATA_WIDTH-1){1'b0}}, slt};
         default: out_o = '0;
      endcase
   end

   assign eq_o = (out_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters with
// valid/ready request and response handshakes and registered results.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NREQ       = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NREQ-1:0]              req_valid_i,
   output logic [NREQ-1:0]              req_ready_o,
   input  logic [NREQ*DATA_WIDTH-1:0]   req_in1_i,
   input  logic [NREQ*DATA_WIDTH-1:0]   req_in2_i,
   input  logic [NREQ*3-1:0]            req_ctrl_i,
   output logic [NREQ-1:0]              resp_valid_o,
   input  logic [NREQ-1:0]              resp_ready_i,
   output logic [DATA_WIDTH-1:0]        resp_data_o,
   output logic                         resp_eq_o,
   output logic                         resp_err_o
);

   arb_state_t            state_q;
   logic                  ptr_q;
   logic                  gnt_q;
   logic [DATA_WIDTH-1:0] in1_q;
   logic [DATA_WIDTH-1:0] in2_q;
   logic [2:0]            ctrl_q;
   logic [NREQ-1:0]       resp_valid_q;
   logic [DATA_WIDTH-1:0] resp_data_q;
   logic                  resp_eq_q;
   logic                  resp_err_q;

   logic                  any_req;
   logic                  gnt;
   logic [DATA_WIDTH-1:0] sel_in1;
   logic [DATA_WIDTH-1:0] sel_in2;
   logic [2:0]            sel_ctrl;
   logic                  legal;
   logic [DATA_WIDTH-1:0] alu_in1;
   logic [DATA_WIDTH-1:0] alu_in2;
   logic [2:0]            alu_ctrl;
   logic [DATA_WIDTH-1:0] alu_out;
   logic                  alu_eq;

   assign any_req = |req_valid_i;
   assign gnt     = req_valid_i[ptr_q] ? ptr_q : ~ptr_q;

   assign sel_in1  = gnt ? req_in1_i[2*DATA_WIDTH-1:DATA_WIDTH]
                         : req_in1_i[DATA_WIDTH-1:0];
   assign sel_in2  = gnt ? req_in2_i[2*DATA_WIDTH-1:DATA_WIDTH]
                         : req_in2_i[DATA_WIDTH-1:0];
   assign sel_ctrl = gnt ? req_ctrl_i[5:3] : req_ctrl_i[2:0];

   // Illegal opcodes are kept away from the ALU entirely.
   assign legal    = is_legal_op(ctrl_q);
   assign alu_in1  = legal ? in1_q  : '0;
   assign alu_in2  = legal ? in2_q  : '0;
   assign alu_ctrl = legal ? ctrl_q : ALU_ADD;

   alu #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_alu (
      .in1_i (alu_in1),
      .in2_i (alu_in2),
      .ctrl_i(alu_ctrl),
      .out_o (alu_out),
      .eq_o  (alu_eq)
   );

   always_comb begin
      req_ready_o = '0;
      if (!rst_i && state_q == ARB_IDLE && any_req) begin
         req_ready_o[gnt] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ARB_IDLE;
         ptr_q        <= 1'b0;
         gnt_q        <= 1'b0;
         in1_q        <= '0;
         in2_q        <= '0;
         ctrl_q       <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
         resp_eq_q    <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            ARB_IDLE: begin
               if (any_req) begin
                  in1_q   <= sel_in1;
                  in2_q   <= sel_in2;
                  ctrl_q  <= sel_ctrl;
                  gnt_q   <= gnt;
                  state_q <= ARB_EXEC;
               end
            end
            ARB_EXEC: begin
               if (legal) begin
                  resp_data_q <= alu_out;
                  resp_eq_q   <= alu_eq;
                  resp_err_q  <= 1'b0;
               end else begin
                  resp_data_q <= '0;
                  resp_eq_q   <= 1'b1;
                  resp_err_q  <= 1'b1;
               end
               resp_valid_q[gnt_q] <= 1'b1;
               state_q             <= ARB_RESP;
            end
            ARB_RESP: begin
               if (resp_ready_i[gnt_q]) begin
                  resp_valid_q <= '0;
                  ptr_q        <= ~gnt_q;
                  state_q      <= ARB_IDLE;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign resp_valid_o = resp_valid_q;
   assign resp_data_o  = resp_data_q;
   assign resp_eq_o    = resp_eq_q;
   assign resp_err_o   = resp_err_q;

endmodule
